// File: rtl/pcie_rq_arb_pkg.sv
// Shared types and helpers for the packet-atomic RQ arbiter.
// Optional build macro: RQ_ARB_PRIO0_EN (strict priority for requester 0).
package pcie_rq_arb_pkg;

    localparam int RQ_ARB_MAX_REQ = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Width of a grant index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pcie_rq_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from last+1 (mod NUM_REQ); with prio0 set, request 0 always wins.
module pcie_rq_rr_pick
    import pcie_rq_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    input  logic               prio0,
    output logic [GRANT_W-1:0] grant,
    output logic               any
);

    logic [NUM_REQ-1:0]   req_m;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;

    always_comb begin
        req_m = req;
        if (prio0) begin
            req_m[0] = 1'b0;
        end
        // Doubling the vector turns the modulo scan into a plain shift.
        req_dbl = {req_m, req_m};
        req_rot = NUM_REQ'(req_dbl >> (32'(last) + 32'd1));
        grant   = last;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                grant = GRANT_W'((32'(last) + 32'd1 + 32'(k)) % 32'(NUM_REQ));
            end
        end
        if (prio0 && req[0]) begin
            grant = '0;
        end
        any = |req;
    end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Packet-atomic arbiter merging NUM_REQ requester RQ AXI-Stream channels.
// Build macro RQ_ARB_PRIO0_EN gives requester 0 strict priority.
module pcie_rq_arbiter
    import pcie_rq_arb_pkg::*;
#(
    parameter int NUM_REQ             = 2,
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int GRANT_W             = grant_w(NUM_REQ)
) (
    input  logic                                   user_clk,
    input  logic                                   reset,
    input  logic                                   arb_enable,
    input  logic [NUM_REQ-1:0]                     s_axis_rq_tvalid,
    output logic [NUM_REQ-1:0]                     s_axis_rq_tready,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
    input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
    input  logic [NUM_REQ-1:0]                     s_axis_rq_tlast,
    input  logic                                   m_axis_rq_tready,
    output logic                                   m_axis_rq_tvalid,
    output logic [C_DATA_WIDTH-1:0]                m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]                  m_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]         m_axis_rq_tuser,
    output logic                                   m_axis_rq_tlast,
    output logic                                   arb_busy,
    output logic [GRANT_W-1:0]                     arb_grant,
    output logic                                   arb_pkt_done
);

`ifdef RQ_ARB_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic               done_q, done_d;

    logic [GRANT_W-1:0] pick_grant;
    logic               pick_any;
    logic               busy;

    logic [C_DATA_WIDTH-1:0]        data_arr [NUM_REQ];
    logic [KEEP_WIDTH-1:0]          keep_arr [NUM_REQ];
    logic [AXI4_RQ_TUSER_WIDTH-1:0] user_arr [NUM_REQ];

    assign busy = (state_q == ARB_BUSY);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi] = s_axis_rq_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
            assign keep_arr[gi] = s_axis_rq_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign user_arr[gi] = s_axis_rq_tuser[gi*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
            assign s_axis_rq_tready[gi] = busy && (grant_q == GRANT_W'(gi)) && m_axis_rq_tready;
        end
    endgenerate

    pcie_rq_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .req   (s_axis_rq_tvalid),
        .last  (last_grant_q),
        .prio0 (PRIO0),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Output mux; everything is forced to zero while no grant is held.
    always_comb begin
        m_axis_rq_tvalid = 1'b0;
        m_axis_rq_tdata  = '0;
        m_axis_rq_tkeep  = '0;
        m_axis_rq_tuser  = '0;
        m_axis_rq_tlast  = 1'b0;
        if (busy) begin
            m_axis_rq_tvalid = s_axis_rq_tvalid[grant_q];
            m_axis_rq_tdata  = data_arr[grant_q];
            m_axis_rq_tkeep  = keep_arr[grant_q];
            m_axis_rq_tuser  = user_arr[grant_q];
            m_axis_rq_tlast  = s_axis_rq_tlast[grant_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        done_d       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (arb_enable && pick_any) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_grant;
                end
            end
            ARB_BUSY: begin
                if (m_axis_rq_tvalid && m_axis_rq_tready && m_axis_rq_tlast) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_q;
                    done_d       = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 is first in line.
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
        end
    end

    assign arb_busy     = busy;
    assign arb_grant    = grant_q;
    assign arb_pkt_done = done_q;

endmodule
